output_port_allocator: RTL and testbench
========================================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 Parameter CREDITS, default 4: downstream buffer depth in flits, range 1..15.
REQ-002 Parameter TIMEOUT, default 255: maximum idle cycles while a grant is held, range 1..4095.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  5  per-input request for this output port; index 0=L, 1=N, 2=E, 3=W, 4=S.
REQ-006 in_valid  input  5  per-input flit-valid strobe.
REQ-007 flit_id  input  15  per-input flit type; input i uses bits [3i+2:3i]; 3'b001 header, 3'b010 body, 3'b100 tail.
REQ-008 credit_in  input  1  one-cycle pulse returning one downstream buffer slot.
REQ-009 grant  output  5  registered one-hot grant; all zeros when idle.
REQ-010 sel  output  3  registered index of the granted input, 0..4; holds 0 when idle.
REQ-011 busy  output  1  registered; high while a grant is held.
REQ-012 xfer  output  1  combinational; high when the granted flit moves downstream this cycle.
REQ-013 credits  output  4  registered count of available downstream slots.
REQ-014 timeout_err  output  1  registered; one-cycle pulse on a watchdog release.

Function
REQ-015 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-016 In IDLE with req != 0, the block SHALL enter ACTIVE on the next edge.
- Winner: round-robin, searching upward from index (last_winner+1) mod 5.
- grant, sel and busy SHALL update on that same edge (1-cycle grant latency).
REQ-017 In IDLE with req == 0, state and outputs SHALL hold.
REQ-018 xfer SHALL equal busy AND in_valid[sel] AND (credits != 0); xfer SHALL be 0 in IDLE.
REQ-019 In ACTIVE, an xfer with flit_id[sel] == 3'b100 SHALL cause release on the next edge.
- Release: state to IDLE, grant to 0, busy to 0, sel to 0, last_winner to the released index.
REQ-020 In ACTIVE, req[sel] low SHALL cause release on the next edge, with last_winner updated as in REQ-019.
REQ-021 After any release, the block SHALL spend at least one cycle in IDLE before the next grant (2-cycle minimum turnaround).
REQ-022 Flit types other than tail SHALL NOT affect grant; flit_id of non-granted inputs SHALL be ignored.
REQ-023 Watchdog: a 12-bit counter SHALL clear on entry to ACTIVE and on every xfer, and increment on each ACTIVE cycle without xfer.
REQ-024 When the watchdog counter equals TIMEOUT, the block SHALL release (as REQ-019) on the next edge and pulse timeout_err high for exactly that one cycle.
REQ-025 Credit counter rules:
- xfer without credit_in: decrement.
- credit_in without xfer: increment, saturating at CREDITS (the extra pulse is dropped).
- xfer and credit_in in the same cycle: unchanged.
REQ-026 credits == 0 SHALL stall transfer (xfer low) without releasing the grant; stall cycles SHALL count toward the watchdog.
REQ-027 Tail xfer, req[sel] drop and watchdog expiry in the same cycle SHALL produce a single release; timeout_err SHALL pulse only if the watchdog expired.

Reset
REQ-028 rst high at a clock edge SHALL force state IDLE, grant 0, sel 0, busy 0, timeout_err 0, watchdog 0, credits CREDITS, and last_winner 4 (input L wins first).
REQ-029 rst SHALL take priority over every other input, including mid-packet; an in-flight packet SHALL be abandoned with no timeout_err pulse.

Verification
REQ-030 After reset, req=5'b10001 -> grant=5'b00001, sel=0 one cycle later.
REQ-031 Input 0 sends header, body, tail with in_valid high -> 3 xfer pulses, credits 4->1, then grant=0, busy=0; while req=5'b10001 is held, the next grant is 5'b10000 after one IDLE cycle.
REQ-032 CREDITS=4, no credit_in, 6-flit packet -> exactly 4 xfer pulses, credits=0, grant held; one credit_in pulse -> credits=1 and one more xfer.
REQ-033 TIMEOUT=8, granted input with in_valid low -> release and a single timeout_err pulse 9 cycles after grant; the next requester is granted afterwards.
REQ-034 credit_in coincident with xfer at credits=2 -> credits stays 2; credit_in at credits=4 -> credits stays 4.
REQ-035 rst asserted mid-packet while granted to input 2 -> next cycle grant=0, credits=4, timeout_err=0; with req=5'b11111, the first grant after reset goes to index 0.

Source files
------------

// File: rtl/output_port_allocator.sv
// Output-port allocator for one router output: round-robin grant across five inputs,
// packet hold until tail, downstream credit tracking and an idle watchdog.
module output_port_allocator #(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [4:0]  in_valid,
    input  logic [14:0] flit_id,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic [2:0]  sel,
    output logic        busy,
    output logic        xfer,
    output logic [3:0]  credits,
    output logic        timeout_err,
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [2:0] FLIT_TAIL = 3'b100;

    state_t      state_q, state_d;
    logic [4:0]  grant_q, grant_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  last_q, last_d;
    logic [11:0] wdog_q, wdog_d;
    logic [3:0]  credits_q, credits_d;
    logic        terr_q, terr_d;

    logic        cur_valid, cur_req;
    logic [2:0]  cur_flit;
    logic [2:0]  win_idx;
    logic        wd_exp, release_now;

    // Signals of the currently selected input.
    always_comb begin
        cur_valid = 1'b0;
        cur_req   = 1'b0;
        cur_flit  = '0;
        for (int i = 0; i < 5; i++) begin
            if (sel_q == 3'(i)) begin
                cur_valid = in_valid[i];
                cur_req   = req[i];
                cur_flit  = flit_id[3*i +: 3];
            end
        end
    end

    // Round-robin pick: first requester at or above last winner + 1, wrapping at 5.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < 5; k++) begin
            idx = (int'(last_q) + 1 + k) % 5;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = 3'(idx);
            end
        end
    end

    assign xfer        = (state_q == ACTIVE) && cur_valid && (credits_q != 4'd0);
    assign wd_exp      = (wdog_q == 12'(TIMEOUT));
    assign release_now = (state_q == ACTIVE) &&
                         ((xfer && cur_flit == FLIT_TAIL) || !cur_req || wd_exp);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ACTIVE;
                    grant_d = 5'd1 << win_idx;
                    sel_d   = win_idx;
                    wdog_d  = '0;
                end
            end
            ACTIVE: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    last_d  = sel_q;
                    wdog_d  = '0;
                    terr_d  = wd_exp;
                end else if (xfer) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Extra credit returns beyond the buffer depth are dropped.
    always_comb begin
        credits_d = credits_q;
        if (xfer && !credit_in)
            credits_d = credits_q - 4'd1;
        else if (credit_in && !xfer && credits_q != 4'(CREDITS))
            credits_d = credits_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= 3'd4;
            wdog_q    <= '0;
            credits_q <= 4'(CREDITS);
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            credits_q <= credits_d;
            terr_q    <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign busy        = (state_q == ACTIVE);
    assign credits     = credits_q;
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed scenarios then random traffic,
// all outputs compared each cycle against a packet-level reference model.
module tb_output_port_allocator;

    localparam int CREDITS = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req, in_valid;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        busy, xfer, timeout_err, state_dbg;
    logic [3:0]  credits;

    output_port_allocator #(.CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .flit_id(flit_id),
        .credit_in(credit_in), .grant(grant), .sel(sel), .busy(busy), .xfer(xfer),
        .credits(credits), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: owner is the granted input or -1, idle counts cycles without progress.
    int m_owner, m_last, m_cred, m_idle;
    logic m_terr;
    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r_rst, input logic [4:0] r, input logic [4:0] v,
                         input logic [14:0] f, input logic c);
        rst = r_rst; req = r; in_valid = v; flit_id = f; credit_in = c;
    endtask

    function automatic logic [14:0] flit_at(input int idx, input logic [2:0] t);
        logic [14:0] f;
        f = '0;
        f[3*idx +: 3] = t;
        return f;
    endfunction

    task automatic model_edge(input logic x);
        logic expired, tail_x;
        if (rst) begin
            m_owner = -1; m_last = 4; m_cred = CREDITS; m_idle = 0; m_terr = 1'b0;
            return;
        end
        m_terr = 1'b0;
        if (m_owner < 0) begin
            if (req != 0) begin
                for (int k = 1; k <= 5; k++)
                    if (m_owner < 0 && req[(m_last + k) % 5]) m_owner = (m_last + k) % 5;
                m_idle = 0;
            end
        end else begin
            expired = (m_idle == TIMEOUT);
            tail_x  = x && (flit_id[3*m_owner +: 3] == 3'b100);
            if (tail_x || !req[m_owner] || expired) begin
                m_last = m_owner; m_owner = -1; m_terr = expired;
            end else begin
                m_idle = x ? 0 : m_idle + 1;
            end
        end
        if (x && !credit_in) m_cred--;
        else if (credit_in && !x && m_cred < CREDITS) m_cred++;
    endtask

    // One clock: check xfer with settled inputs, clock, then check registered outputs.
    task automatic tick();
        logic exp_x;
        #1;
        exp_x = (m_owner >= 0) && in_valid[m_owner] && (m_cred > 0);
        check("xfer", 32'(xfer), 32'(exp_x));
        @(posedge clk);
        model_edge(exp_x);
        @(negedge clk);
        check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(1) << m_owner);
        check("sel", 32'(sel), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("state_dbg", 32'(state_dbg), 32'(m_owner >= 0));
        check("credits", 32'(credits), 32'(m_cred));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    initial begin
        int terr_count;
        logic [4:0] r;
        logic [2:0] t;
        logic [14:0] f;
        m_owner = -1; m_last = 4; m_cred = CREDITS; m_idle = 0; m_terr = 1'b0;
        drive(1'b1, 5'b0, 5'b0, 15'b0, 1'b0);
        @(negedge clk);
        tick(); tick();

        // Grant latency and a three-flit packet from L, then S after one idle cycle.
        drive(1'b0, 5'b10001, 5'b0, 15'b0, 1'b0);
        tick();
        check("first_grant", 32'(grant), 32'b00001);
        drive(1'b0, 5'b10001, 5'b00001, flit_at(0, 3'b001), 1'b0); tick();
        drive(1'b0, 5'b10001, 5'b00001, flit_at(0, 3'b010), 1'b0); tick();
        drive(1'b0, 5'b10001, 5'b00001, flit_at(0, 3'b100), 1'b0); tick();
        check("credits_after_pkt", 32'(credits), 32'd1);
        check("released", 32'(grant), 32'd0);
        drive(1'b0, 5'b10001, 5'b0, 15'b0, 1'b0); tick();
        check("rr_next", 32'(grant), 32'b10000);
        drive(1'b0, 5'b0, 5'b0, 15'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("credit_saturate", 32'(credits), 32'd4);

        // Credit exhaustion stalls without releasing; one credit allows one more flit.
        drive(1'b0, 5'b00010, 5'b00010, flit_at(1, 3'b010), 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("stall_credits", 32'(credits), 32'd0);
        check("stall_grant", 32'(grant), 32'b00010);
        drive(1'b0, 5'b00010, 5'b00010, flit_at(1, 3'b010), 1'b1); tick();
        check("credit_return", 32'(credits), 32'd1);
        drive(1'b0, 5'b00010, 5'b00010, flit_at(1, 3'b010), 1'b0); tick();
        drive(1'b0, 5'b0, 5'b0, 15'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();

        // Credit return coincident with a transfer leaves the count unchanged.
        drive(1'b0, 5'b00100, 5'b00100, flit_at(2, 3'b010), 1'b0);
        tick(); tick(); tick();
        check("credits_two", 32'(credits), 32'd2);
        drive(1'b0, 5'b00100, 5'b00100, flit_at(2, 3'b010), 1'b1); tick();
        check("credit_coincident", 32'(credits), 32'd2);
        drive(1'b0, 5'b0, 5'b0, 15'b0, 1'b1); tick(); tick(); tick();

        // Watchdog: W granted but never valid; S waits behind it.
        drive(1'b0, 5'b11000, 5'b0, 15'b0, 1'b0);
        tick();
        check("wd_grant", 32'(grant), 32'b01000);
        terr_count = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (timeout_err) terr_count++;
        end
        check("wd_pulse_at_9", 32'(timeout_err), 32'd1);
        tick();
        if (timeout_err) terr_count++;
        check("wd_pulse_count", 32'(terr_count), 32'd1);
        check("wd_next_grant", 32'(grant), 32'b10000);
        drive(1'b0, 5'b0, 5'b0, 15'b0, 1'b0); tick(); tick();

        // Reset mid-packet on input E.
        drive(1'b0, 5'b00100, 5'b00100, flit_at(2, 3'b001), 1'b0); tick(); tick();
        drive(1'b1, 5'b00100, 5'b00100, flit_at(2, 3'b010), 1'b0); tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_terr", 32'(timeout_err), 32'd0);
        drive(1'b0, 5'b11111, 5'b0, 15'b0, 1'b0); tick();
        check("rst_first_grant", 32'(grant), 32'b00001);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            r = 5'($urandom_range(0, 31));
            if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
            f = 15'($urandom);
            if (m_owner >= 0) begin
                case ($urandom_range(0, 3))
                    0: t = 3'b001;
                    1: t = 3'b010;
                    2: t = 3'b100;
                    default: t = 3'($urandom);
                endcase
                f[3*m_owner +: 3] = t;
            end
            drive(($urandom_range(0, 99) == 0), r, 5'($urandom_range(0, 31)), f,
                  ($urandom_range(0, 2) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
